// File: rtl/counter_pkg.sv
// Shared definitions for the up/down counter family: direction encodings,
// the next-count result record, and the wrap/clamp rules as pure functions.
// The SAT behaviour used by UPDOWN_COUNTER_SAT_EN is expressed here through
// the sat argument; the default build ties that argument low.
package counter_pkg;

   localparam logic CNT_UP = 1'b1;
   localparam logic CNT_DN = 1'b0;

   // Next-count result. Values are carried at 32 bits so one function serves
   // every counter width; callers keep only their low WIDTH bits.
   typedef struct packed {
      logic [31:0] val;
      logic        wrap;
      logic        blocked;
   } cnt_next_t;

   // One counting step modulo max+1. With sat set, the boundary holds
   // instead of wrapping and the step is reported as blocked.
   function automatic cnt_next_t cnt_next(input logic [31:0] cur,
                                          input logic [31:0] max,
                                          input logic        dir,
                                          input logic        sat);
      cnt_next_t r;
      r.val     = cur;
      r.wrap    = 1'b0;
      r.blocked = 1'b0;
      if (dir == CNT_UP) begin
         if (cur >= max) begin
            if (sat) begin
               r.val     = max;
               r.blocked = 1'b1;
            end else begin
               r.val  = 32'd0;
               r.wrap = 1'b1;
            end
         end else begin
            r.val = cur + 32'd1;
         end
      end else begin
         if (cur == 32'd0) begin
            if (sat) begin
               r.val     = 32'd0;
               r.blocked = 1'b1;
            end else begin
               r.val  = max;
               r.wrap = 1'b1;
            end
         end else begin
            r.val = cur - 32'd1;
         end
      end
      return r;
   endfunction

   // Parallel-load values above the terminal count are clamped to it.
   function automatic logic [31:0] cnt_clamp(input logic [31:0] v,
                                             input logic [31:0] max);
      return (v > max) ? max : v;
   endfunction

endpackage

// File: rtl/updown_counter_next.sv
// Combinational next-state helper for updown_counter_param: computes the
// counted value with its wrap / blocked flags and the clamped load value.
// Holds no state; all registers live in the top module.
module updown_counter_next
   import counter_pkg::*;
#(
   parameter int unsigned      WIDTH = 4,
   parameter logic [WIDTH-1:0] MAX   = {WIDTH{1'b1}}
) (
   input  logic [WIDTH-1:0] q_i,
   input  logic             up_dn_i,
   input  logic             sat_i,
   input  logic [WIDTH-1:0] load_val_i,
   output logic [WIDTH-1:0] q_nxt_o,
   output logic             wrap_o,
   output logic             block_o,
   output logic [WIDTH-1:0] load_nxt_o
);

   cnt_next_t   step;
   logic [31:0] load_ext;
   logic        unused_hi;

   // Evaluate the shared counting and clamping rules at 32 bits.
   always_comb begin
      step     = cnt_next(32'(q_i), 32'(MAX), up_dn_i, sat_i);
      load_ext = cnt_clamp(32'(load_val_i), 32'(MAX));
   end

   assign q_nxt_o    = step.val[WIDTH-1:0];
   assign wrap_o     = step.wrap;
   assign block_o    = step.blocked;
   assign load_nxt_o = load_ext[WIDTH-1:0];

   // Upper bits are always zero since both inputs are below 2**WIDTH.
   assign unused_hi  = ^{step.val, load_ext};

endmodule

// File: rtl/updown_counter_param.sv
// Parameterised modulo-(MAX+1) up/down counter with synchronous load,
// registered one-cycle wrap pulse (tc) and sticky wrap flag (ovf).
// Optional feature macro: UPDOWN_COUNTER_SAT_EN adds a sat input that makes
// the count stop at the boundary instead of wrapping.
module updown_counter_param
   import counter_pkg::*;
#(
   parameter int unsigned      WIDTH = 4,
   parameter logic [WIDTH-1:0] MAX   = {WIDTH{1'b1}}
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             ovf_clr,
`ifdef UPDOWN_COUNTER_SAT_EN
   input  logic             sat,
`endif
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             ovf
);

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             tc_q, tc_d;
   logic             ovf_q, ovf_d;
   logic             blk_q, blk_d;   // previous edge was a boundary-blocked count

   logic [WIDTH-1:0] q_nxt;
   logic [WIDTH-1:0] load_nxt;
   logic             wrap;
   logic             block;
   logic             sat_w;

`ifdef UPDOWN_COUNTER_SAT_EN
   assign sat_w = sat;
`else
   assign sat_w = 1'b0;
`endif

   updown_counter_next #(
      .WIDTH (WIDTH),
      .MAX   (MAX)
   ) u_next (
      .q_i        (cnt_q),
      .up_dn_i    (up_dn),
      .sat_i      (sat_w),
      .load_val_i (load_val),
      .q_nxt_o    (q_nxt),
      .wrap_o     (wrap),
      .block_o    (block),
      .load_nxt_o (load_nxt)
   );

   // Next state: load beats count; wrap or first blocked step pulses tc,
   // and a wrap/block sets ovf even when ovf_clr is asserted on that edge.
   always_comb begin
      cnt_d = cnt_q;
      tc_d  = 1'b0;
      ovf_d = ovf_q & ~ovf_clr;
      blk_d = 1'b0;
      if (load) begin
         cnt_d = load_nxt;
      end else if (en) begin
         cnt_d = q_nxt;
         blk_d = block;
         if (wrap) begin
            tc_d  = 1'b1;
            ovf_d = 1'b1;
         end
         if (block) begin
            tc_d  = ~blk_q;
            ovf_d = 1'b1;
         end
      end
   end

   // State registers, cleared asynchronously so reset discards any pending step.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
         tc_q  <= 1'b0;
         ovf_q <= 1'b0;
         blk_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         tc_q  <= tc_d;
         ovf_q <= ovf_d;
         blk_q <= blk_d;
      end
   end

   assign q   = cnt_q;
   assign tc  = tc_q;
   assign ovf = ovf_q;

endmodule

// File: tb/tb_updown_counter_param.sv
// Self-checking bench for updown_counter_param at WIDTH=4, MAX=9.
// Directed scenarios followed by randomized traffic against a modular-
// arithmetic reference model.
module tb_updown_counter_param;

   localparam int W   = 4;
   localparam int MAX = 9;

   logic         clk;
   logic         reset_n;
   logic         en;
   logic         up_dn;
   logic         load;
   logic [W-1:0] load_val;
   logic         ovf_clr;
`ifdef UPDOWN_COUNTER_SAT_EN
   logic         sat;
`endif
   logic [W-1:0] q;
   logic         tc;
   logic         ovf;

   int checks = 0;
   int errors = 0;

   // reference model state
   int mq   = 0;
   int mtc  = 0;
   int movf = 0;
   int mblk = 0;

   updown_counter_param #(
      .WIDTH (W),
      .MAX   (4'(MAX))
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .en       (en),
      .up_dn    (up_dn),
      .load     (load),
      .load_val (load_val),
      .ovf_clr  (ovf_clr),
`ifdef UPDOWN_COUNTER_SAT_EN
      .sat      (sat),
`endif
      .q        (q),
      .tc       (tc),
      .ovf      (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp)
      else begin
         errors++;
         $error("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".q"},   32'(q),   32'(mq));
      check({tag, ".tc"},  32'(tc),  32'(mtc));
      check({tag, ".ovf"}, 32'(ovf), 32'(movf));
   endtask

   // Reference: count is arithmetic modulo MAX+1; a wrap is seen as the
   // result jumping the "wrong" way relative to the direction of travel.
   task automatic model_edge(input bit s);
      int nq;
      int nt;
      int nb;
      int ev;
      nq = mq; nt = 0; nb = 0; ev = 0;
      if (load) begin
         nq = (int'(load_val) > MAX) ? MAX : int'(load_val);
      end else if (en) begin
         if (up_dn) nq = (mq + 1) % (MAX + 1);
         else       nq = (mq + MAX) % (MAX + 1);
         if ((up_dn && nq < mq) || (!up_dn && nq > mq)) begin
            ev = 1;
            if (s) begin
               nq = mq; nb = 1; nt = (mblk == 0);
            end else begin
               nt = 1;
            end
         end
      end
      mq   = nq;
      mtc  = nt;
      mblk = nb;
      movf = ev ? 1 : (ovf_clr ? 0 : movf);
   endtask

   task automatic step(input string tag, input bit e, input bit u, input bit l,
                       input int lv, input bit oc, input bit s);
      en       = e;
      up_dn    = u;
      load     = l;
      load_val = W'(lv);
      ovf_clr  = oc;
`ifdef UPDOWN_COUNTER_SAT_EN
      sat      = s;
`endif
      model_edge(s);
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   initial begin
      reset_n = 1'b0; en = 0; up_dn = 0; load = 0; load_val = '0; ovf_clr = 0;
`ifdef UPDOWN_COUNTER_SAT_EN
      sat = 0;
`endif
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      @(negedge clk);
      reset_n = 1'b1;

      // 12 up edges: 1..9,0,1,2 with tc only alongside 0
      for (int i = 0; i < 12; i++) step("up12", 1, 1, 0, 0, 0, 0);
      check("up12.final_q", 32'(q), 32'd2);
      check("up12.ovf_sticky", 32'(ovf), 32'd1);

      // hold with en=0
      step("hold", 0, 1, 0, 0, 0, 0);

      // clear ovf, go to 0, then wrap down with ovf_clr on the same edge
      step("clr", 0, 0, 0, 0, 1, 0);
      check("clr.ovf", 32'(ovf), 32'd0);
      step("ld0", 0, 0, 1, 0, 0, 0);
      step("dnwrap", 1, 0, 0, 0, 1, 0);
      check("dnwrap.q", 32'(q), 32'd9);
      check("dnwrap.tc", 32'(tc), 32'd1);
      check("dnwrap.ovf_set_wins", 32'(ovf), 32'd1);

      // load above MAX clamps, beats en, no tc; then wrap up
      step("ld13", 1, 1, 1, 13, 0, 0);
      check("ld13.q", 32'(q), 32'd9);
      check("ld13.tc", 32'(tc), 32'd0);
      step("ld13.up", 1, 1, 0, 0, 0, 0);
      check("ld13.up.tc", 32'(tc), 32'd1);

      // asynchronous reset between edges while q=5
      step("ld4", 0, 1, 1, 4, 0, 0);
      step("to5", 1, 1, 0, 0, 0, 0);
      check("to5.q", 32'(q), 32'd5);
      #2;
      reset_n = 1'b0;
      mq = 0; mtc = 0; movf = 0; mblk = 0;
      #1;
      check_all("async_rst");
      @(negedge clk);
      reset_n = 1'b1;
      step("post_rst", 1, 1, 0, 0, 0, 0);
      check("post_rst.q", 32'(q), 32'd1);

      // direction reversal with no dead cycle
      step("rev.up", 1, 1, 0, 0, 0, 0);
      step("rev.dn", 1, 0, 0, 0, 0, 0);
      check("rev.dn.q", 32'(q), 32'd1);

`ifdef UPDOWN_COUNTER_SAT_EN
      step("sat.ld8", 0, 1, 1, 8, 1, 1);
      step("sat.up9", 1, 1, 0, 0, 0, 1);
      check("sat.up9.tc", 32'(tc), 32'd0);
      step("sat.blk1", 1, 1, 0, 0, 0, 1);
      check("sat.blk1.q", 32'(q), 32'd9);
      check("sat.blk1.tc", 32'(tc), 32'd1);
      step("sat.blk2", 1, 1, 0, 0, 0, 1);
      check("sat.blk2.tc", 32'(tc), 32'd0);
      check("sat.blk2.ovf", 32'(ovf), 32'd1);
`endif

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         step("rand",
              ($urandom_range(0, 9) != 0),
              $urandom_range(0, 1) == 1,
              ($urandom_range(0, 11) == 0),
              int'($urandom_range(0, 15)),
              ($urandom_range(0, 7) == 0),
`ifdef UPDOWN_COUNTER_SAT_EN
              ($urandom_range(0, 3) == 0)
`else
              1'b0
`endif
             );
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/updown_counter_param.md
UPDOWN_COUNTER_PARAM -- requirements
Module: updown_counter_param

Interface
REQ-001 SHALL have parameter WIDTH, default 4: counter width in bits, legal range 2..32.
REQ-002 SHALL have parameter MAX, default 2**WIDTH-1: terminal value and modulus MAX+1, legal range 1..2**WIDTH-1.
REQ-003 SHALL have port clk, input, 1 bit: single clock, rising-edge active.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port en, input, 1 bit: count enable.
REQ-006 SHALL have port up_dn, input, 1 bit: direction, 1 = up, 0 = down.
REQ-007 SHALL have port load, input, 1 bit: synchronous parallel load.
REQ-008 SHALL have port load_val, input, WIDTH bits: value to load.
REQ-009 SHALL have port ovf_clr, input, 1 bit: clears the sticky overflow flag.
REQ-010 SHALL have port q, output, WIDTH bits: registered count.
REQ-011 SHALL have port tc, output, 1 bit: registered one-cycle wrap pulse.
REQ-012 SHALL have port ovf, output, 1 bit: sticky wrap flag.

Function
REQ-013 SHALL update all state only on rising clk, except on reset.
REQ-014 SHALL apply priority load > en; with en=0 and load=0, q holds.
REQ-015 SHALL load q <= load_val on load=1, or q <= MAX if load_val > MAX; a load never asserts tc or sets ovf.
REQ-016 SHALL count up (en=1, up_dn=1): q < MAX gives q+1; q == MAX gives 0 (wrap).
REQ-017 SHALL count down (en=1, up_dn=0): q > 0 gives q-1; q == 0 gives MAX (wrap).
REQ-018 SHALL assert tc for exactly the one cycle following each wrap edge, so tc and the wrapped q value appear together; tc is 0 otherwise.
REQ-019 SHALL produce one tc pulse per wrap on consecutive wraps (MAX=1, continuous counting), so tc may stay high on back-to-back cycles.
REQ-020 SHALL set ovf on the wrap edge and hold it until an ovf_clr edge; when a wrap and ovf_clr occur on the same edge, ovf=1 (set wins).
REQ-021 SHALL take the new up_dn value on the next edge when it changes mid-count, with no dead cycle.
REQ-022 SHALL perform all arithmetic in WIDTH bits with no carry out.

Reset
REQ-023 SHALL force q=0, tc=0 and ovf=0 immediately while reset_n=0, independent of clk.
REQ-024 SHALL abandon any operation in progress (load or count) when reset asserts, with no pending effect.
REQ-025 SHALL resume counting on the first rising clk after reset_n deasserts.

Configuration
REQ-026 SHALL define macro UPDOWN_COUNTER_SAT_EN.
REQ-027 With UPDOWN_COUNTER_SAT_EN defined, SHALL add input sat, 1 bit; sat=1 holds q at MAX (up) or at 0 (down) instead of wrapping, asserts tc for one cycle on the first cycle the boundary blocks a count, and sets ovf.
REQ-028 With UPDOWN_COUNTER_SAT_EN undefined, SHALL have no sat port and always wrap.

Structure
REQ-029 SHALL take its direction constants (CNT_UP=1, CNT_DN=0) from shared package counter_pkg.
REQ-030 SHALL place the next-value function (wrap and clamp rules) in counter_pkg.
REQ-031 SHALL use one combinational sub-module, updown_counter_next, to compute next q and the wrap flag; registers stay in the top module.

Verification (WIDTH=4, MAX=9)
REQ-032 Reset, then en=1, up_dn=1 for 12 edges -> q=1..9,0,1,2; tc=1 only with the q=0 cycle; ovf=1 from then on.
REQ-033 From q=0, en=1, up_dn=0 -> q=9 with tc=1 and ovf=1; then ovf_clr=1 on that same edge as a second wrap -> ovf stays 1.
REQ-034 load=1, load_val=13, en=1 -> q=9, tc=0; next edge counting up -> q=0 with tc=1.
REQ-035 Assert reset_n=0 between clk edges while q=5 -> q=0, tc=0, ovf=0 at once; release -> q=1 after the first edge.
REQ-036 With UPDOWN_COUNTER_SAT_EN defined and sat=1, up from q=8 -> q=9, then 9 held; tc=1 for one cycle only; ovf=1.
